// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master: command codes, FSM states,
// latched request payload and default prescaler width.
package i2c_pkg;

    localparam int unsigned I2C_DW_DEFAULT = 4;
    localparam int unsigned I2C_ACK_BIT    = 8;

    localparam logic [1:0] I2C_CMD_START = 2'b00;
    localparam logic [1:0] I2C_CMD_STOP  = 2'b01;
    localparam logic [1:0] I2C_CMD_WRITE = 2'b10;
    localparam logic [1:0] I2C_CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_STOP  = 3'd2,
        ST_BIT   = 3'd3,
        ST_DONE  = 3'd4
    } i2c_state_t;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] data;
        logic       ack;
    } i2c_req_t;

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-bit timebase: DW-bit prescaler that advances a 2-bit phase q once
// every 2^DW enabled cycles.
module i2c_phase_timer #(
    parameter int unsigned DW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic       tick_c,
    output logic [1:0] q
);

    logic [DW-1:0] cnt;

    assign tick_c = en && (cnt == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= '0;
        end else if (clr) begin
            cnt <= '0;
            q   <= '0;
        end else if (en) begin
            cnt <= cnt + DW'(1);
            if (tick_c) begin
                q <= q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_byte_engine.sv
// Byte-level I2C master: executes START/STOP/WRITE/READ commands on open-drain
// SCL/SDA enables, one command at a time through a stb/ready handshake.
module i2c_byte_engine
    import i2c_pkg::*;
#(
    parameter int unsigned DW = I2C_DW_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    input  logic [7:0] data_in,
    input  logic       ack_in,
    input  logic [1:0] cmd,
    input  logic       stb,
    output logic [7:0] data_out,
    output logic       ack_out,
    output logic       ready
);

    i2c_state_t state, state_nxt;
    i2c_req_t   req, req_nxt;
    logic [3:0] bit_idx, bit_idx_nxt;
    logic [8:0] sh, sh_nxt;
    logic       scl_nxt, sda_nxt, ready_nxt, ack_out_nxt;
    logic [7:0] data_out_nxt;
    logic       accept, busy, tick, phase_end, bit_sda;
    logic [1:0] q;

    assign accept    = stb && ready;
    assign busy      = (state == ST_START) || (state == ST_STOP) || (state == ST_BIT);
    assign phase_end = tick && (q == 2'd3);

    i2c_phase_timer #(.DW(DW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .en     (busy),
        .tick_c (tick),
        .q      (q)
    );

    // SDA pull for the current bit: data bits only pulled on WRITE, ACK slot only on READ
    always_comb begin
        bit_sda = 1'b0;
        if (bit_idx == 4'(I2C_ACK_BIT)) begin
            bit_sda = (req.cmd == I2C_CMD_READ) ? ~req.ack : 1'b0;
        end else if (req.cmd == I2C_CMD_WRITE) begin
            bit_sda = ~req.data[~bit_idx[2:0]];
        end
    end

    always_comb begin
        state_nxt    = state;
        req_nxt      = req;
        bit_idx_nxt  = bit_idx;
        sh_nxt       = sh;
        scl_nxt      = scl_oe;
        sda_nxt      = sda_oe;
        data_out_nxt = data_out;
        ack_out_nxt  = ack_out;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    req_nxt     = '{cmd: cmd, data: data_in, ack: ack_in};
                    bit_idx_nxt = 4'd0;
                    case (cmd)
                        I2C_CMD_START: state_nxt = ST_START;
                        I2C_CMD_STOP:  state_nxt = ST_STOP;
                        default:       state_nxt = ST_BIT;
                    endcase
                end
            end
            ST_START: begin
                scl_nxt = (q == 2'd0) || (q == 2'd3);
                sda_nxt = q[1];
                if (phase_end) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_STOP: begin
                scl_nxt = (q == 2'd0);
                sda_nxt = ~q[1];
                if (phase_end) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_BIT: begin
                scl_nxt = (q == 2'd0) || (q == 2'd3);
                sda_nxt = bit_sda;
                if (tick && (q == 2'd2)) begin
                    sh_nxt = {sh[7:0], sda_i};
                end
                if (phase_end) begin
                    if (bit_idx == 4'(I2C_ACK_BIT)) begin
                        state_nxt    = ST_DONE;
                        data_out_nxt = sh[8:1];
                        ack_out_nxt  = sh[0];
                    end else begin
                        bit_idx_nxt = bit_idx + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        ready_nxt = (state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            req      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            ready    <= 1'b1;
            data_out <= '0;
            ack_out  <= 1'b0;
        end else begin
            state    <= state_nxt;
            req      <= req_nxt;
            bit_idx  <= bit_idx_nxt;
            sh       <= sh_nxt;
            scl_oe   <= scl_nxt;
            sda_oe   <= sda_nxt;
            ready    <= ready_nxt;
            data_out <= data_out_nxt;
            ack_out  <= ack_out_nxt;
        end
    end

endmodule
